// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: one-hot registered grant, 1-cycle latency.
// Owner keeps the grant for up to w_eff non-stalled cycles; stall freezes a live grant.
module arbiter_wrr #(
  parameter int VECTOR_IN = 8,
  parameter int WEIGHT_W  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic [VECTOR_IN-1:0]          request_vector,
  input  logic [VECTOR_IN*WEIGHT_W-1:0] weight,
  output logic [VECTOR_IN-1:0]          grant,
  output logic                          grant_valid,
  output logic [$clog2(VECTOR_IN)-1:0]  grant_idx
);

  localparam int IW = $clog2(VECTOR_IN);

  typedef enum logic [1:0] {HOLD_STALL, HOLD_WEIGHT, ARBITRATE} mode_t;

  mode_t                mode;
  logic [IW-1:0]        last_owner;
  logic [IW-1:0]        last_owner_nx;
  logic [IW-1:0]        grant_idx_nx;
  logic [IW-1:0]        winner;
  logic [WEIGHT_W-1:0]  cnt;
  logic [WEIGHT_W-1:0]  cnt_nx;
  logic [WEIGHT_W-1:0]  owner_w;
  logic [WEIGHT_W-1:0]  owner_weff;
  logic [VECTOR_IN-1:0] grant_nx;
  logic                 any_req;

  // Weight is read live, so a change applies at the very next hold comparison.
  always_comb begin
    owner_w    = weight[grant_idx*WEIGHT_W +: WEIGHT_W];
    owner_weff = (owner_w == '0) ? WEIGHT_W'(1) : owner_w;
  end

  // First loop yields the lowest requester overall; the second overrides it with
  // the lowest requester above last_owner when one exists.
  always_comb begin
    winner  = '0;
    any_req = |request_vector;
    for (int i = VECTOR_IN - 1; i >= 0; i--) begin
      if (request_vector[i]) winner = IW'(i);
    end
    for (int i = VECTOR_IN - 1; i >= 0; i--) begin
      if (request_vector[i] && (IW'(i) > last_owner)) winner = IW'(i);
    end
  end

  always_comb begin
    mode = ARBITRATE;
    if (stall && grant_valid)
      mode = HOLD_STALL;
    else if (grant_valid && request_vector[grant_idx] && (cnt < owner_weff))
      mode = HOLD_WEIGHT;
  end

  always_comb begin
    grant_nx      = grant;
    grant_idx_nx  = grant_idx;
    last_owner_nx = last_owner;
    cnt_nx        = cnt;
    case (mode)
      HOLD_STALL: ;
      HOLD_WEIGHT: cnt_nx = cnt + WEIGHT_W'(1);
      default: begin
        if (any_req) begin
          grant_nx         = '0;
          grant_nx[winner] = 1'b1;
          grant_idx_nx     = winner;
          last_owner_nx    = winner;
          cnt_nx           = WEIGHT_W'(1);
        end else begin
          grant_nx     = '0;
          grant_idx_nx = '0;
          cnt_nx       = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      cnt         <= '0;
      last_owner  <= IW'(VECTOR_IN - 1);
    end else begin
      grant       <= grant_nx;
      grant_valid <= |grant_nx;
      grant_idx   <= grant_idx_nx;
      cnt         <= cnt_nx;
      last_owner  <= last_owner_nx;
    end
  end

endmodule

// File: doc/arbiter_wrr.md
ARBITER_WRR -- requirements
Module: arbiter_wrr

Interface
REQ-001 SHALL have parameter VECTOR_IN, default 8, number of requesters (>=2).
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each per-requester weight field.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  hold current non-zero grant.
REQ-006 SHALL have port request_vector  input  VECTOR_IN  per-requester request, bit i = requester i.
REQ-007 SHALL have port weight  input  VECTOR_IN*WEIGHT_W  quasi-static weights; requester i uses bits [i*WEIGHT_W +: WEIGHT_W].
REQ-008 SHALL have port grant  output  VECTOR_IN  registered one-hot (or zero) grant.
REQ-009 SHALL have port grant_valid  output  1  registered, equals OR of grant.
REQ-010 SHALL have port grant_idx  output  $clog2(VECTOR_IN)  registered binary index of granted bit; 0 when grant is 0.

Function
REQ-011 SHALL register grant one cycle after the request_vector sample that produced it (1cc latency).
REQ-012 SHALL keep internal state: last_owner pointer ($clog2(VECTOR_IN) bits), hold counter cnt (WEIGHT_W bits).
REQ-013 SHALL use effective weight w_eff(i) = weight(i), except weight 0 treated as 1.
REQ-014 SHALL evaluate each cycle in priority order: HOLD_STALL, HOLD_WEIGHT, ARBITRATE.
REQ-015 HOLD_STALL: stall=1 and grant!=0 -> grant, grant_idx, cnt, last_owner unchanged, even if owner's request drops.
REQ-016 HOLD_WEIGHT: stall=0, grant!=0, owner still requesting, cnt < w_eff(owner) -> grant unchanged, cnt increments by 1.
REQ-017 ARBITRATE otherwise: grant lowest-index requester with index > last_owner; if none, lowest-index requester overall.
REQ-018 On ARBITRATE with a winner: grant <= one-hot(winner), grant_idx <= winner, last_owner <= winner, cnt <= 1.
REQ-019 On ARBITRATE with request_vector=0: grant <= 0, grant_idx <= 0, cnt <= 0, last_owner retained.
REQ-020 stall=1 with grant=0 SHALL arbitrate normally; resulting grant then held by REQ-015 until stall=0.
REQ-021 A requester SHALL hold grant for at most w_eff consecutive non-stalled cycles while other requests pend; stall cycles do not count.
REQ-022 cnt SHALL never exceed w_eff(owner); no wrap of cnt.
REQ-023 grant SHALL never have more than one bit set.
REQ-024 Weight changes SHALL take effect at the next HOLD_WEIGHT comparison; no other side effect.

Reset
REQ-025 reset=0 SHALL asynchronously force grant=0, grant_valid=0, grant_idx=0, cnt=0, last_owner=VECTOR_IN-1 (first arbitration starts at index 0).
REQ-026 Reset asserted mid-hold SHALL discard hold/stall state; first post-reset arbitration follows REQ-025 pointer.

Verification (VECTOR_IN=4, WEIGHT_W=4)
REQ-027 All weights 1, request_vector=4'b1111 constant -> grant 0001,0010,0100,1000,0001 on cycles 1..5; grant_idx 0,1,2,3,0.
REQ-028 weight0=3, weight1=1, request_vector=4'b0011 -> grant 0001 x3, 0010 x1, 0001 x3, repeating.
REQ-029 grant=0010, stall=1 for 3 cycles with request_vector=4'b0100 -> grant stays 0010; cycle after stall=0 -> grant 0100.
REQ-030 grant=0001 then request_vector=0 for 2 cycles -> grant 0, grant_valid 0; then request_vector=4'b0011 -> grant 0010 (pointer retained).
REQ-031 weight2=0, request_vector=4'b0101 -> grant alternates 0001,0100 every cycle (weight 0 behaves as 1).
REQ-032 reset=0 asynchronously while grant=1000, cnt=2 -> grant 0 same cycle without clock edge; after release with request_vector=4'b1001 -> grant 0001.
